// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
// gate_next() holds the barrier state machine used by both gates.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    OPEN,
    PASSING,
    REPORT,
    CLEAR
  } gate_state_t;

  localparam logic CLASS_GENERAL = 1'b0;
  localparam logic CLASS_UNI     = 1'b1;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_OPEN_TIMEOUT    = 1000;

  // The exit gate has no CHECK state: it leaves IDLE straight to OPEN.
  function automatic gate_state_t gate_next(
    input gate_state_t state,
    input logic        is_entry,
    input logic        detect,
    input logic        pass,
    input logic        timeout,
    input logic        space_ok,
    input logic        grant
  );
    gate_state_t nxt;
    nxt = state;
    case (state)
      IDLE:    if (detect) nxt = is_entry ? CHECK : OPEN;
      CHECK:   nxt = space_ok ? OPEN : CLEAR;
      OPEN: begin
        if (pass)         nxt = PASSING;
        else if (timeout) nxt = CLEAR;
      end
      PASSING: if (!pass)  nxt = REPORT;
      REPORT:  if (grant)  nxt = CLEAR;
      CLEAR:   if (!detect) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic barrier_of(input gate_state_t state);
    return (state == OPEN) || (state == PASSING);
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a debounce counter: the filtered output
// flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_filtered
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filtered;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_filtered <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // NOTE: non-blocking so r_sync2 takes last cycle's r_sync1; blocking
      // assignments here would collapse the two synchronizer stages into one.
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filtered) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_filtered <= r_sync2;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_filtered = r_filtered;

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller: debounced loop sensors, one FSM per gate,
// and an arbiter that emits at most one occupancy event per cycle.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int OPEN_TIMEOUT    = DEFAULT_OPEN_TIMEOUT,
  parameter int TMR_W           = $clog2(OPEN_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       start,
  input  logic       entry_detect,
  input  logic       entry_is_uni,
  input  logic       entry_pass,
  input  logic       exit_detect,
  input  logic       exit_is_uni,
  input  logic       exit_pass,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_barrier_open,
  output logic       exit_barrier_open,
  output logic       entry_denied,
  output logic [1:0] gate_fault
);

  logic w_entry_detect_f, w_entry_pass_f, w_exit_detect_f, w_exit_pass_f;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_detect (
    .clk(clk), .rst_n(start), .i_raw(entry_detect), .o_filtered(w_entry_detect_f)
  );
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_pass (
    .clk(clk), .rst_n(start), .i_raw(entry_pass), .o_filtered(w_entry_pass_f)
  );
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_detect (
    .clk(clk), .rst_n(start), .i_raw(exit_detect), .o_filtered(w_exit_detect_f)
  );
  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_pass (
    .clk(clk), .rst_n(start), .i_raw(exit_pass), .o_filtered(w_exit_pass_f)
  );

  logic             r_entry_uni_s1, r_entry_uni_s2, r_exit_uni_s1, r_exit_uni_s2;
  logic             r_entry_class, r_exit_class;
  gate_state_t      r_entry_state, r_exit_state;
  gate_state_t      w_entry_next, w_exit_next;
  logic [TMR_W-1:0] r_entry_tmr, r_exit_tmr;

  logic w_space_ok, w_entry_timeout, w_exit_timeout;
  logic w_entry_fault, w_exit_fault, w_entry_grant, w_exit_grant;

  logic       r_car_entered, r_is_uni_car_entered, r_car_exited, r_is_uni_car_exited;
  logic       r_entry_barrier, r_exit_barrier, r_entry_denied;
  logic [1:0] r_gate_fault;

  // NOTE: every always_comb output gets a value on every path, so no latch
  // can be inferred; add new outputs with a default at the top.
  always_comb begin
    w_space_ok      = (r_entry_class == CLASS_UNI) ? uni_is_vacated_space : is_vacated_space;
    w_entry_timeout = (r_entry_tmr == TMR_W'(OPEN_TIMEOUT - 1));
    w_exit_timeout  = (r_exit_tmr == TMR_W'(OPEN_TIMEOUT - 1));
    w_entry_fault   = (r_entry_state == OPEN) && !w_entry_pass_f && w_entry_timeout;
    w_exit_fault    = (r_exit_state == OPEN) && !w_exit_pass_f && w_exit_timeout;
    // Entry wins a simultaneous REPORT; exit is granted the following cycle.
    w_entry_grant   = (r_entry_state == REPORT);
    w_exit_grant    = (r_exit_state == REPORT) && !w_entry_grant;
    w_entry_next    = gate_next(r_entry_state, 1'b1, w_entry_detect_f, w_entry_pass_f,
                                w_entry_timeout, w_space_ok, w_entry_grant);
    w_exit_next     = gate_next(r_exit_state, 1'b0, w_exit_detect_f, w_exit_pass_f,
                                w_exit_timeout, 1'b1, w_exit_grant);
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_entry_uni_s1 <= 1'b0;
      r_entry_uni_s2 <= 1'b0;
      r_exit_uni_s1  <= 1'b0;
      r_exit_uni_s2  <= 1'b0;
      r_entry_class  <= CLASS_GENERAL;
      r_exit_class   <= CLASS_GENERAL;
      r_entry_state  <= IDLE;
      r_exit_state   <= IDLE;
      r_entry_tmr    <= '0;
      r_exit_tmr     <= '0;
    end else begin
      r_entry_uni_s1 <= entry_is_uni;
      r_entry_uni_s2 <= r_entry_uni_s1;
      r_exit_uni_s1  <= exit_is_uni;
      r_exit_uni_s2  <= r_exit_uni_s1;
      if (r_entry_state == IDLE && w_entry_detect_f) r_entry_class <= r_entry_uni_s2;
      if (r_exit_state == IDLE && w_exit_detect_f)   r_exit_class  <= r_exit_uni_s2;
      r_entry_state <= w_entry_next;
      r_exit_state  <= w_exit_next;
      r_entry_tmr   <= (r_entry_state == OPEN && w_entry_next == OPEN) ?
                       r_entry_tmr + TMR_W'(1) : '0;
      r_exit_tmr    <= (r_exit_state == OPEN && w_exit_next == OPEN) ?
                       r_exit_tmr + TMR_W'(1) : '0;
    end
  end

  // Barrier drive is decoded from the next state so it changes with the state.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      r_car_entered        <= 1'b0;
      r_is_uni_car_entered <= 1'b0;
      r_car_exited         <= 1'b0;
      r_is_uni_car_exited  <= 1'b0;
      r_entry_barrier      <= 1'b0;
      r_exit_barrier       <= 1'b0;
      r_entry_denied       <= 1'b0;
      r_gate_fault         <= 2'b00;
    end else begin
      r_car_entered        <= w_entry_grant;
      r_is_uni_car_entered <= w_entry_grant & r_entry_class;
      r_car_exited         <= w_exit_grant;
      r_is_uni_car_exited  <= w_exit_grant & r_exit_class;
      r_entry_barrier      <= barrier_of(w_entry_next);
      r_exit_barrier       <= barrier_of(w_exit_next);
      r_entry_denied       <= (r_entry_state == CHECK) && !w_space_ok;
      r_gate_fault         <= r_gate_fault | {w_exit_fault, w_entry_fault};
    end
  end

  assign car_entered        = r_car_entered;
  assign is_uni_car_entered = r_is_uni_car_entered;
  assign car_exited         = r_car_exited;
  assign is_uni_car_exited  = r_is_uni_car_exited;
  assign entry_barrier_open = r_entry_barrier;
  assign exit_barrier_open  = r_exit_barrier;
  assign entry_denied       = r_entry_denied;
  assign gate_fault         = r_gate_fault;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller: a vector table for the basic
// entry flows plus hand-written sequences for the multi-cycle corner cases.
module tb_parking_gate_controller;

  logic       clk;
  logic       start;
  logic       entry_detect, entry_is_uni, entry_pass;
  logic       exit_detect, exit_is_uni, exit_pass;
  logic       uni_is_vacated_space, is_vacated_space;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic       entry_barrier_open, exit_barrier_open, entry_denied;
  logic [1:0] gate_fault;

  int n_checks = 0;
  int n_pass   = 0;

  parking_gate_controller #(
    .DEBOUNCE_CYCLES(4),
    .OPEN_TIMEOUT   (16)
  ) dut (
    .clk                 (clk),
    .start               (start),
    .entry_detect        (entry_detect),
    .entry_is_uni        (entry_is_uni),
    .entry_pass          (entry_pass),
    .exit_detect         (exit_detect),
    .exit_is_uni         (exit_is_uni),
    .exit_pass           (exit_pass),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .entry_barrier_open  (entry_barrier_open),
    .exit_barrier_open   (exit_barrier_open),
    .entry_denied        (entry_denied),
    .gate_fault          (gate_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output bundle: {entry_bar, exit_bar, car_entered, uni_entered,
  //                 car_exited, uni_exited, entry_denied, gate_fault[1:0]}
  typedef struct {
    string      name;
    logic       ed, eu, ep, xd, xu, xp, usp, gsp;
    int         cycles;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] outs();
    return {entry_barrier_open, exit_barrier_open, car_entered, is_uni_car_entered,
            car_exited, is_uni_car_exited, entry_denied, gate_fault};
  endfunction

  function automatic vec_t mk(input string name, input logic ed, input logic eu,
                              input logic ep, input logic usp, input logic gsp,
                              input int cycles, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.ed = ed; v.eu = eu; v.ep = ep;
    v.xd = 1'b0; v.xu = 1'b0; v.xp = 1'b0;
    v.usp = usp; v.gsp = gsp; v.cycles = cycles; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance n rising edges and stop on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int   ent_k, ext_k, ent_cnt, ext_cnt, hi, guard;
    logic overlap, uni_e, uni_x, seen;

    start = 1'b0;
    entry_detect = 1'b0; entry_is_uni = 1'b0; entry_pass = 1'b0;
    exit_detect  = 1'b0; exit_is_uni  = 1'b0; exit_pass  = 1'b0;
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;

    step(3);
    check("reset_outputs", 32'(outs()), 32'h0);
    start = 1'b1;

    // General entry: barrier at detect+8, event 2 cycles after filtered pass falls.
    vecs.push_back(mk("t1_before_open",   1, 0, 0, 1, 1, 7,  9'h000));
    vecs.push_back(mk("t1_open",          1, 0, 0, 1, 1, 1,  9'h100));
    vecs.push_back(mk("t1_passing",       1, 0, 1, 1, 1, 10, 9'h100));
    vecs.push_back(mk("t1_report_wait",   1, 0, 0, 1, 1, 7,  9'h000));
    vecs.push_back(mk("t1_car_entered",   1, 0, 0, 1, 1, 1,  9'h040));
    vecs.push_back(mk("t1_pulse_end",     1, 0, 0, 1, 1, 1,  9'h000));
    vecs.push_back(mk("t1_no_retrigger",  1, 0, 0, 1, 1, 10, 9'h000));
    vecs.push_back(mk("t1_release",       0, 0, 0, 1, 1, 8,  9'h000));
    // Uni car, uni area full: denied, retried after the loop clears.
    vecs.push_back(mk("t2_setup",         0, 1, 0, 0, 1, 4,  9'h000));
    vecs.push_back(mk("t2_before_check",  1, 1, 0, 0, 1, 7,  9'h000));
    vecs.push_back(mk("t2_denied",        1, 1, 0, 0, 1, 1,  9'h004));
    vecs.push_back(mk("t2_denied_end",    1, 1, 0, 0, 1, 1,  9'h000));
    vecs.push_back(mk("t2_hold_in_clear", 1, 1, 0, 0, 1, 10, 9'h000));
    vecs.push_back(mk("t2_release",       0, 1, 0, 0, 1, 8,  9'h000));
    vecs.push_back(mk("t2_retry_wait",    1, 1, 0, 0, 1, 7,  9'h000));
    vecs.push_back(mk("t2_denied_again",  1, 1, 0, 0, 1, 1,  9'h004));
    vecs.push_back(mk("t2_end",           0, 1, 0, 0, 1, 1,  9'h000));

    for (int i = 0; i < vecs.size(); i++) begin
      entry_detect = vecs[i].ed; entry_is_uni = vecs[i].eu; entry_pass = vecs[i].ep;
      exit_detect  = vecs[i].xd; exit_is_uni  = vecs[i].xu; exit_pass  = vecs[i].xp;
      uni_is_vacated_space = vecs[i].usp; is_vacated_space = vecs[i].gsp;
      step(vecs[i].cycles);
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end

    // Bounce: detect toggling every 2 cycles never passes the filter.
    entry_is_uni = 1'b0; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    step(10);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      entry_detect = ~entry_detect;
      for (int j = 0; j < 2; j++) begin
        step(1);
        seen |= entry_barrier_open | entry_denied | car_entered;
      end
    end
    for (int j = 0; j < 10; j++) begin
      step(1);
      seen |= entry_barrier_open | entry_denied | car_entered;
    end
    check("bounce_rejected", 32'(seen), 32'h0);

    // Simultaneous REPORT: entry granted first, exit one cycle later.
    exit_is_uni = 1'b1;
    step(2);
    entry_detect = 1'b1; exit_detect = 1'b1;
    step(9);
    check("sim_both_open", 32'({entry_barrier_open, exit_barrier_open}), 32'h3);
    entry_pass = 1'b1; exit_pass = 1'b1;
    step(10);
    entry_pass = 1'b0; exit_pass = 1'b0;
    ent_k = -1; ext_k = -1; ent_cnt = 0; ext_cnt = 0;
    overlap = 1'b0; uni_e = 1'b1; uni_x = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (car_entered) begin ent_k = k; ent_cnt++; uni_e = is_uni_car_entered; end
      if (car_exited)  begin ext_k = k; ext_cnt++; uni_x = is_uni_car_exited;  end
      if (car_entered && car_exited) overlap = 1'b1;
    end
    check("sim_entry_cycle", 32'(ent_k), 32'd8);
    check("sim_exit_cycle", 32'(ext_k), 32'd9);
    check("sim_event_counts", 32'({ent_cnt[3:0], ext_cnt[3:0]}), 32'h11);
    check("sim_no_overlap", 32'(overlap), 32'h0);
    check("sim_classes", 32'({uni_e, uni_x}), 32'h1);
    entry_detect = 1'b0; exit_detect = 1'b0; exit_is_uni = 1'b0;
    step(10);

    // Timeout: exit barrier open exactly 16 cycles, sticky fault, no event.
    exit_detect = 1'b1;
    step(6);
    check("to_not_yet_open", 32'(exit_barrier_open), 32'h0);
    step(1);
    check("to_open", 32'(exit_barrier_open), 32'h1);
    hi = 1; guard = 0; seen = 1'b0;
    while (exit_barrier_open && guard < 40) begin
      step(1);
      guard++;
      if (exit_barrier_open) hi++;
      seen |= car_exited;
    end
    check("to_open_cycles", 32'(hi), 32'd16);
    check("to_fault_set", 32'(gate_fault), 32'h2);
    step(10);
    seen |= car_exited | exit_barrier_open;
    check("to_no_event_no_retrigger", 32'(seen), 32'h0);
    exit_detect = 1'b0;
    step(10);
    check("to_fault_sticky", 32'(gate_fault), 32'h2);

    // Reset while the entry gate is in PASSING.
    entry_detect = 1'b1;
    step(8);
    entry_pass = 1'b1;
    step(10);
    check("rst_passing_open", 32'(entry_barrier_open), 32'h1);
    #2 start = 1'b0;
    #1 check("rst_async_drop", 32'(outs()), 32'h0);
    entry_pass = 1'b0;
    step(2);
    check("rst_held", 32'(outs()), 32'h0);
    start = 1'b1;
    step(7);
    check("rst_recheck_wait", 32'({entry_barrier_open, car_entered}), 32'h0);
    step(1);
    check("rst_reopen", 32'(entry_barrier_open), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
